// File: rtl/pipe_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_sequencer
//
// Main control unit for the 8-bit, 4-stage (IF/ID, EX, MEM, WB) pipelined core.
// Decodes the opcode of the 16-bit instruction sitting in ID and drives the
// ID-stage datapath controls combinationally. Memory and writeback controls
// travel down an EX -> MEM -> WB shadow pipeline. Load-use stalls insert a
// bubble into EX, and flushes squash the EX slot. A RUN/DRAIN/HALTED state
// machine freezes fetch on HALT and lets older instructions retire before
// reporting halted.
//
// Optional build macro: PIPE_CTRL_PERF_EN adds saturating performance counters
// (perf_retired, perf_stalls, perf_flushes).
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   instr_ID[15:0]    instruction in ID, opcode = [15:12]
//   stall, flush      load-use stall / control-hazard flush
//   resume            one-cycle pulse that leaves HALTED
//   opcode, ImmSrc, ALUsrc, dir, is_unsigned, Branch, jump
//                     ID-stage controls (combinational)
//   MemRead_EX        load in EX (for the hazard unit)
//   MemRead_MEM, MemWrite_MEM, RegWrite_MEM, ResultSrc_MEM
//                     controls of the instruction in MEM
//   RegWrite_WB       writeback pending in WB
//   fetch_hold        freeze PC and IF/ID
//   halt              core halted (registered)
//   perf_*            event counters (PIPE_CTRL_PERF_EN only)
// -----------------------------------------------------------------------------
module pipe_ctrl_sequencer #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr_ID,
    input  logic        stall,
    input  logic        flush,
    input  logic        resume,
    output logic [3:0]  opcode,
    output logic [1:0]  ImmSrc,
    output logic        ALUsrc,
    output logic        dir,
    output logic        is_unsigned,
    output logic        Branch,
    output logic        jump,
    output logic        MemRead_EX,
    output logic        MemRead_MEM,
    output logic        MemWrite_MEM,
    output logic        RegWrite_MEM,
    output logic        ResultSrc_MEM,
    output logic        RegWrite_WB,
    output logic        fetch_hold,
    output logic        halt
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_retired,
    output logic [CNT_W-1:0] perf_stalls,
    output logic [CNT_W-1:0] perf_flushes
`endif
);

    typedef enum logic [1:0] {
        S_RUN    = 2'b00,
        S_DRAIN  = 2'b01,
        S_HALTED = 2'b10
    } state_t;

    // Drain counter is loaded with DRAIN_CYCLES-1; keep at least one bit.
    localparam int DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DC_W-1:0] DC_LOAD = DC_W'(DRAIN_CYCLES - 1);

    // Bundle bit positions: {MemRead, MemWrite, RegWrite, ResultSrc}
    localparam int B_MR = 3;
    localparam int B_MW = 2;
    localparam int B_RW = 1;
    localparam int B_RS = 0;

    state_t          state_q, state_d;
    logic [DC_W-1:0] cnt_q, cnt_d;
    logic            halt_q, halt_d;
    logic [3:0]      ex_q, ex_d;
    logic [3:0]      mem_q, mem_d;
    logic            wb_rw_q, wb_rw_d;

    logic            dec_mr_s, dec_mw_s, dec_rw_s, dec_rs_s;
    logic            dec_alusrc_s, dec_br_s, dec_jmp_s, dec_halt_s;
    logic            dec_dir_s, dec_uns_s;
    logic [1:0]      dec_imm_s;
    logic [3:0]      dec_bundle_s;
    logic            run_s;
    logic            capture_s;

    // Only the opcode and bit 0 of the instruction matter to control.
    logic            unused_instr_bits;
    assign unused_instr_bits = ^instr_ID[11:1];

    assign run_s        = (state_q == S_RUN);
    assign dec_bundle_s = {dec_mr_s, dec_mw_s, dec_rw_s, dec_rs_s};
    // EX captures a real decode only while running and neither squashed nor stalled.
    assign capture_s    = run_s && !flush && !stall;

    // Opcode decode of the instruction in ID.
    always_comb begin
        dec_mr_s     = 1'b0;
        dec_mw_s     = 1'b0;
        dec_rw_s     = 1'b0;
        dec_rs_s     = 1'b0;
        dec_alusrc_s = 1'b0;
        dec_imm_s    = 2'b00;
        dec_br_s     = 1'b0;
        dec_jmp_s    = 1'b0;
        dec_dir_s    = 1'b0;
        dec_uns_s    = 1'b0;
        dec_halt_s   = 1'b0;
        case (instr_ID[15:12])
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin
                dec_rw_s = 1'b1;
            end
            4'h5: begin
                dec_rw_s  = 1'b1;
                dec_dir_s = instr_ID[0];
            end
            4'h6: begin
                dec_rw_s     = 1'b1;
                dec_alusrc_s = 1'b1;
            end
            4'h7: begin
                dec_rw_s  = 1'b1;
                dec_uns_s = instr_ID[0];
            end
            4'h8: begin
                dec_mr_s     = 1'b1;
                dec_rw_s     = 1'b1;
                dec_rs_s     = 1'b1;
                dec_alusrc_s = 1'b1;
            end
            4'h9: begin
                dec_mw_s     = 1'b1;
                dec_alusrc_s = 1'b1;
                dec_imm_s    = 2'b01;
            end
            4'hA, 4'hB: begin
                dec_br_s  = 1'b1;
                dec_imm_s = 2'b10;
            end
            4'hC: begin
                dec_jmp_s = 1'b1;
                dec_imm_s = 2'b11;
            end
            4'hF: begin
                dec_halt_s = 1'b1;
            end
            default: begin
                dec_rw_s = 1'b0;
            end
        endcase
    end

    // Shadow pipeline next values: bubble into EX unless a real capture.
    always_comb begin
        mem_d   = ex_q;
        wb_rw_d = mem_q[B_RW];
        if (capture_s) begin
            ex_d = dec_bundle_s;
        end else begin
            ex_d = 4'b0000;
        end
    end

    // RUN/DRAIN/HALTED next-state and drain countdown.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                // A stalled HALT is retried next cycle; a flushed HALT is dropped.
                if (dec_halt_s && !stall && !flush) begin
                    state_d = S_DRAIN;
                    cnt_d   = DC_LOAD;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (cnt_q == {DC_W{1'b0}}) begin
                    state_d = S_HALTED;
                end else begin
                    cnt_d = cnt_q - DC_W'(1);
                end
            end
            S_HALTED: begin
                if (resume) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_HALTED;
                end
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = {DC_W{1'b0}};
            end
        endcase
        halt_d = (state_d == S_HALTED);
    end

    // State, drain counter and shadow pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RUN;
            cnt_q   <= {DC_W{1'b0}};
            halt_q  <= 1'b0;
            ex_q    <= 4'b0000;
            mem_q   <= 4'b0000;
            wb_rw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            halt_q  <= halt_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_rw_q <= wb_rw_d;
        end
    end

    assign opcode        = instr_ID[15:12];
    assign ImmSrc        = dec_imm_s;
    assign ALUsrc        = dec_alusrc_s;
    assign dir           = dec_dir_s;
    assign is_unsigned   = dec_uns_s;
    assign Branch        = dec_br_s  & run_s;
    assign jump          = dec_jmp_s & run_s;
    assign MemRead_EX    = ex_q[B_MR];
    assign MemRead_MEM   = mem_q[B_MR];
    assign MemWrite_MEM  = mem_q[B_MW];
    assign RegWrite_MEM  = mem_q[B_RW];
    assign ResultSrc_MEM = mem_q[B_RS];
    assign RegWrite_WB   = wb_rw_q;
    // Fetch freezes in the same cycle the HALT is seen in ID.
    assign fetch_hold    = !run_s || dec_halt_s;
    assign halt          = halt_q;

`ifdef PIPE_CTRL_PERF_EN
    logic             ex_vld_q, ex_vld_d;
    logic             mem_vld_q, mem_vld_d;
    logic             wb_vld_q, wb_vld_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    logic [CNT_W-1:0] stl_q, stl_d;
    logic [CNT_W-1:0] fls_q, fls_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // Valid tag rides alongside the bundle; HALT itself does not retire.
    always_comb begin
        ex_vld_d  = capture_s && !dec_halt_s;
        mem_vld_d = ex_vld_q;
        wb_vld_d  = mem_vld_q;
        ret_d     = ret_q;
        stl_d     = stl_q;
        fls_d     = fls_q;
        if (state_q != S_HALTED) begin
            if (wb_vld_q) begin
                ret_d = sat_inc(ret_q);
            end else begin
                ret_d = ret_q;
            end
            if (stall && run_s) begin
                stl_d = sat_inc(stl_q);
            end else begin
                stl_d = stl_q;
            end
            if (flush) begin
                fls_d = sat_inc(fls_q);
            end else begin
                fls_d = fls_q;
            end
        end else begin
            ret_d = ret_q;
        end
    end

    // Valid tags and performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_vld_q  <= 1'b0;
            mem_vld_q <= 1'b0;
            wb_vld_q  <= 1'b0;
            ret_q     <= {CNT_W{1'b0}};
            stl_q     <= {CNT_W{1'b0}};
            fls_q     <= {CNT_W{1'b0}};
        end else begin
            ex_vld_q  <= ex_vld_d;
            mem_vld_q <= mem_vld_d;
            wb_vld_q  <= wb_vld_d;
            ret_q     <= ret_d;
            stl_q     <= stl_d;
            fls_q     <= fls_d;
        end
    end

    assign perf_retired = ret_q;
    assign perf_stalls  = stl_q;
    assign perf_flushes = fls_q;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for pipe_ctrl_sequencer (default build).
// A behavioural model (opcode table, queue of issued bundles, halt timing kept
// as cycle numbers) is compared against every DUT output once per cycle, and
// directed sequences add literal expectations at the interesting cycles.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl_sequencer;

    localparam int DRAIN = 3;

    logic        clk;
    logic        reset;
    logic [15:0] instr_ID;
    logic        stall, flush, resume;
    logic [3:0]  opcode;
    logic [1:0]  ImmSrc;
    logic        ALUsrc, dir, is_unsigned, Branch, jump;
    logic        MemRead_EX, MemRead_MEM, MemWrite_MEM, RegWrite_MEM, ResultSrc_MEM;
    logic        RegWrite_WB, fetch_hold, halt;

    pipe_ctrl_sequencer #(.DRAIN_CYCLES(DRAIN), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .instr_ID(instr_ID),
        .stall(stall), .flush(flush), .resume(resume),
        .opcode(opcode), .ImmSrc(ImmSrc), .ALUsrc(ALUsrc), .dir(dir),
        .is_unsigned(is_unsigned), .Branch(Branch), .jump(jump),
        .MemRead_EX(MemRead_EX), .MemRead_MEM(MemRead_MEM),
        .MemWrite_MEM(MemWrite_MEM), .RegWrite_MEM(RegWrite_MEM),
        .ResultSrc_MEM(ResultSrc_MEM), .RegWrite_WB(RegWrite_WB),
        .fetch_hold(fetch_hold), .halt(halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Opcode table row: [8:7] ImmSrc, [6] ALUsrc, [5] Branch, [4] jump,
    // [3:0] {MemRead, MemWrite, RegWrite, ResultSrc}
    logic [8:0] tbl [16];

    // Model state: bundles issued into EX (q[2]=EX, q[1]=MEM, q[0]=WB),
    // cycle count, and the first cycle that was not RUN (-1 while running).
    logic [3:0] q [$];
    int         cyc;
    int         left_at;

    task automatic cmp(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic step(input logic [15:0] i, input logic s, input logic f, input logic r);
        @(negedge clk);
        instr_ID = i;
        stall    = s;
        flush    = f;
        resume   = r;
        #3;
    endtask

    initial begin
        for (int k = 0; k < 16; k++) tbl[k] = 9'h000;
        for (int k = 0; k < 6; k++) tbl[k] = {2'b00, 1'b0, 1'b0, 1'b0, 4'b0010};
        tbl[6]  = {2'b00, 1'b1, 1'b0, 1'b0, 4'b0010};
        tbl[7]  = {2'b00, 1'b0, 1'b0, 1'b0, 4'b0010};
        tbl[8]  = {2'b00, 1'b1, 1'b0, 1'b0, 4'b1011};
        tbl[9]  = {2'b01, 1'b1, 1'b0, 1'b0, 4'b0100};
        tbl[10] = {2'b10, 1'b0, 1'b1, 1'b0, 4'b0000};
        tbl[11] = {2'b10, 1'b0, 1'b1, 1'b0, 4'b0000};
        tbl[12] = {2'b11, 1'b0, 1'b0, 1'b1, 4'b0000};
    end

    // Model update on each clock edge (or at once on reset).
    initial begin
        logic       run_m, halted_m;
        logic [3:0] op_m, cap;
        q = '{4'h0, 4'h0, 4'h0};
        cyc = 0;
        left_at = -1;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                q = '{4'h0, 4'h0, 4'h0};
                cyc = 0;
                left_at = -1;
            end else begin
                op_m     = instr_ID[15:12];
                run_m    = (left_at < 0);
                halted_m = !run_m && (cyc >= left_at + DRAIN);
                cap      = (run_m && !stall && !flush) ? tbl[op_m][3:0] : 4'h0;
                q.push_back(cap);
                void'(q.pop_front());
                if (run_m && op_m == 4'hF && !stall && !flush) left_at = cyc + 1;
                else if (halted_m && resume) left_at = -1;
                cyc++;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        logic       run_c, halted_c;
        logic [3:0] op;
        logic [8:0] row;
        forever begin
            @(negedge clk);
            #2;
            if (cmp_en) begin
                op       = instr_ID[15:12];
                row      = tbl[op];
                run_c    = (left_at < 0);
                halted_c = !run_c && (cyc >= left_at + DRAIN);
                cmp("m_opcode",        opcode,               op);
                cmp("m_immsrc",        4'(ImmSrc),           4'(row[8:7]));
                cmp("m_alusrc",        4'(ALUsrc),           4'(row[6]));
                cmp("m_dir",           4'(dir),              (op == 4'h5) ? 4'(instr_ID[0]) : 4'h0);
                cmp("m_is_unsigned",   4'(is_unsigned),      (op == 4'h7) ? 4'(instr_ID[0]) : 4'h0);
                cmp("m_branch",        4'(Branch),           4'(row[5] & run_c));
                cmp("m_jump",          4'(jump),             4'(row[4] & run_c));
                cmp("m_memread_ex",    4'(MemRead_EX),       4'(q[2][3]));
                cmp("m_memread_mem",   4'(MemRead_MEM),      4'(q[1][3]));
                cmp("m_memwrite_mem",  4'(MemWrite_MEM),     4'(q[1][2]));
                cmp("m_regwrite_mem",  4'(RegWrite_MEM),     4'(q[1][1]));
                cmp("m_resultsrc_mem", 4'(ResultSrc_MEM),    4'(q[1][0]));
                cmp("m_regwrite_wb",   4'(RegWrite_WB),      4'(q[0][1]));
                cmp("m_fetch_hold",    4'(fetch_hold),       4'(!run_c || op == 4'hF));
                cmp("m_halt",          4'(halt),             4'(halted_c));
            end
        end
    end

    // Directed stimulus with hand-computed literal expectations.
    initial begin
        reset = 1'b1; instr_ID = 16'hD000; stall = 1'b0; flush = 1'b0; resume = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        cmp("rst_halt",        4'(halt),        4'h0);
        cmp("rst_fetch_hold",  4'(fetch_hold),  4'h0);
        cmp("rst_memread_ex",  4'(MemRead_EX),  4'h0);
        cmp("rst_memread_mem", 4'(MemRead_MEM), 4'h0);
        cmp("rst_regwrite_wb", 4'(RegWrite_WB), 4'h0);
        cmp_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // LOAD latency
        step(16'h8123, 1'b0, 1'b0, 1'b0);
        cmp("t1_alusrc", 4'(ALUsrc), 4'h1);
        cmp("t1_immsrc", 4'(ImmSrc), 4'h0);
        step(16'hD000, 1'b0, 1'b0, 1'b0);
        cmp("t1_memread_ex", 4'(MemRead_EX), 4'h1);
        step(16'hD000, 1'b0, 1'b0, 1'b0);
        cmp("t1_memread_mem",   4'(MemRead_MEM),   4'h1);
        cmp("t1_resultsrc_mem", 4'(ResultSrc_MEM), 4'h1);
        step(16'hD000, 1'b0, 1'b0, 1'b0);
        cmp("t1_regwrite_wb", 4'(RegWrite_WB), 4'h1);
        step(16'hD000, 1'b0, 1'b0, 1'b0);

        // LOAD then ADD stalled one cycle
        step(16'h8000, 1'b0, 1'b0, 1'b0);
        step(16'h0123, 1'b1, 1'b0, 1'b0);
        step(16'h0123, 1'b0, 1'b0, 1'b0);
        cmp("t2_memread_ex_bubble", 4'(MemRead_EX),  4'h0);
        cmp("t2_memread_mem",       4'(MemRead_MEM), 4'h1);
        step(16'hD000, 1'b0, 1'b0, 1'b0);
        cmp("t2_regwrite_mem_bubble", 4'(RegWrite_MEM), 4'h0);
        cmp("t2_regwrite_wb_load",    4'(RegWrite_WB),  4'h1);
        step(16'hD000, 1'b0, 1'b0, 1'b0);
        cmp("t2_regwrite_mem_add", 4'(RegWrite_MEM), 4'h1);

        // BEQ under flush
        step(16'h0456, 1'b0, 1'b0, 1'b0);
        step(16'hA012, 1'b0, 1'b1, 1'b0);
        cmp("t3_branch", 4'(Branch), 4'h1);
        cmp("t3_immsrc", 4'(ImmSrc), 4'h2);
        step(16'hD000, 1'b0, 1'b0, 1'b0);
        step(16'hD000, 1'b0, 1'b0, 1'b0);
        cmp("t3_regwrite_mem_squash", 4'(RegWrite_MEM), 4'h0);
        cmp("t3_regwrite_wb_add",     4'(RegWrite_WB),  4'h1);

        // stall together with flush on a LOAD, then other opcodes
        step(16'h8000, 1'b1, 1'b1, 1'b0);
        step(16'h9000, 1'b0, 1'b0, 1'b0);
        cmp("t3_sf_memread_ex", 4'(MemRead_EX), 4'h0);
        cmp("t3_store_immsrc",  4'(ImmSrc),     4'h1);
        step(16'hC345, 1'b0, 1'b0, 1'b0);
        cmp("t3_jump",        4'(jump),   4'h1);
        cmp("t3_jump_immsrc", 4'(ImmSrc), 4'h3);
        step(16'h5001, 1'b0, 1'b0, 1'b0);
        cmp("t3_store_memwrite_mem", 4'(MemWrite_MEM), 4'h1);
        cmp("t3_shift_dir",          4'(dir),          4'h1);
        cmp("t3_shift_unsigned",     4'(is_unsigned),  4'h0);
        step(16'h7001, 1'b0, 1'b0, 1'b0);
        cmp("t3_slt_unsigned", 4'(is_unsigned), 4'h1);
        cmp("t3_slt_dir",      4'(dir),         4'h0);
        step(16'h6000, 1'b0, 1'b0, 1'b0);
        cmp("t3_addi_alusrc", 4'(ALUsrc), 4'h1);
        step(16'hB000, 1'b0, 1'b0, 1'b0);
        cmp("t3_bne_branch", 4'(Branch), 4'h1);

        // HALT: flushed one dropped, stalled one retried, then drain/halt/resume
        step(16'hF000, 1'b0, 1'b1, 1'b0);
        cmp("t4_flushed_halt_hold", 4'(fetch_hold), 4'h1);
        step(16'hD000, 1'b0, 1'b0, 1'b0);
        cmp("t4_discarded_hold", 4'(fetch_hold), 4'h0);
        step(16'hF000, 1'b1, 1'b0, 1'b0);
        cmp("t4_stalled_halt_hold", 4'(fetch_hold), 4'h1);
        step(16'hF000, 1'b0, 1'b0, 1'b0);
        cmp("t4_halt_hold", 4'(fetch_hold), 4'h1);
        step(16'hA000, 1'b0, 1'b0, 1'b0);
        cmp("t4_drain1_branch", 4'(Branch),     4'h0);
        cmp("t4_drain1_hold",   4'(fetch_hold), 4'h1);
        cmp("t4_drain1_halt",   4'(halt),       4'h0);
        step(16'hD000, 1'b0, 1'b0, 1'b1);
        cmp("t4_drain2_halt", 4'(halt), 4'h0);
        step(16'hD000, 1'b0, 1'b0, 1'b0);
        cmp("t4_drain3_halt", 4'(halt), 4'h0);
        step(16'hD000, 1'b0, 1'b0, 1'b0);
        cmp("t4_halted",      4'(halt),       4'h1);
        cmp("t4_halted_hold", 4'(fetch_hold), 4'h1);
        step(16'h8000, 1'b0, 1'b0, 1'b0);
        step(16'hD000, 1'b0, 1'b0, 1'b0);
        cmp("t4_halted_no_issue", 4'(MemRead_EX), 4'h0);
        step(16'hD000, 1'b0, 1'b0, 1'b1);
        cmp("t4_resume_cycle_halt", 4'(halt), 4'h1);
        step(16'hD000, 1'b0, 1'b0, 1'b0);
        cmp("t4_resumed_halt", 4'(halt),       4'h0);
        cmp("t4_resumed_hold", 4'(fetch_hold), 4'h0);

        // asynchronous reset in the middle of DRAIN
        step(16'h8000, 1'b0, 1'b0, 1'b0);
        step(16'hF000, 1'b0, 1'b0, 1'b0);
        step(16'hD000, 1'b0, 1'b0, 1'b0);
        cmp("t5_pre_memread_mem", 4'(MemRead_MEM), 4'h1);
        cmp("t5_pre_hold",        4'(fetch_hold),  4'h1);
        reset = 1'b1;
        #1;
        cmp("t5_rst_halt",         4'(halt),         4'h0);
        cmp("t5_rst_hold",         4'(fetch_hold),   4'h0);
        cmp("t5_rst_memread_mem",  4'(MemRead_MEM),  4'h0);
        cmp("t5_rst_regwrite_mem", 4'(RegWrite_MEM), 4'h0);
        cmp("t5_rst_memread_ex",   4'(MemRead_EX),   4'h0);
        @(negedge clk);
        reset = 1'b0;
        step(16'h8000, 1'b0, 1'b0, 1'b0);
        step(16'hD000, 1'b0, 1'b0, 1'b0);
        cmp("t5_after_memread_ex", 4'(MemRead_EX), 4'h1);
        cmp("t5_after_hold",       4'(fetch_hold), 4'h0);

        repeat (2) step(16'hD000, 1'b0, 1'b0, 1'b0);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_sequencer.md
Name: pipe_ctrl_sequencer

Overview:
- Main control unit for the 8-bit, 4-stage (IF/ID, EX, MEM, WB) pipelined core with 16-bit instructions and 8 registers.
- Decodes the opcode of the instruction in ID and drives the ID-stage datapath controls.
- Carries memory and writeback controls down an EX→MEM→WB shadow pipeline, inserting bubbles on load-use stall and squashing on flush.
- Runs a halt/drain/resume state machine that freezes fetch.

Parameters:
DRAIN_CYCLES, 3, cycles between HALT decode and halted; lets EX/MEM/WB retire.
CNT_W, 16, perf counter width (used only with the optional feature).

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
instr_ID  in  16  instruction in ID; opcode = [15:12]
stall  in  1  load-use stall from hazard unit
flush  in  1  control-hazard flush
resume  in  1  one-cycle pulse; leave HALTED
opcode  out  4  ALU opcode to datapath
ImmSrc  out  2  00 I6, 01 S6, 10 B8, 11 J12
ALUsrc  out  1  1 = immediate operand
dir  out  1  shift direction, instr_ID[0]
is_unsigned  out  1  unsigned compare, instr_ID[0]
Branch  out  1  conditional branch in ID
jump  out  1  unconditional jump in ID
MemRead_EX  out  1  load in EX (hazard unit)
MemRead_MEM  out  1  load in MEM
MemWrite_MEM  out  1  store in MEM
RegWrite_MEM  out  1  writeback pending, MEM
ResultSrc_MEM  out  1  1 = memory data
RegWrite_WB  out  1  writeback pending, WB
fetch_hold  out  1  freeze PC and IF/ID
halt  out  1  core halted

Behaviour:
- Opcode map (instr_ID[15:12]):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR: RegWrite, ALUsrc=0.
  - 5 SHIFT: RegWrite, ALUsrc=0, dir driven.
  - 6 ADDI: RegWrite, ALUsrc=1, ImmSrc=00.
  - 7 SLT: RegWrite, is_unsigned driven.
  - 8 LOAD: MemRead, RegWrite, ResultSrc=1, ALUsrc=1, ImmSrc=00.
  - 9 STORE: MemWrite, ALUsrc=1, ImmSrc=01.
  - A BEQ, B BNE: Branch=1, ImmSrc=10.
  - C JUMP: jump=1, ImmSrc=11.
  - D, E: NOP, all controls 0.
  - F: HALT.
  - Unlisted outputs are 0. dir and is_unsigned are 0 unless the opcode is 5 or 7.
- ID-stage outputs are combinational from instr_ID. When state != RUN, Branch, jump and all pipelined enables are forced to 0.
- Shadow pipeline. Bundle = {MemRead, MemWrite, RegWrite, ResultSrc}. Registers EX, MEM, WB.
  - Every cycle: MEM <= EX, WB <= MEM.
  - EX <= 0 (bubble) if stall, flush, or state != RUN. Otherwise EX <= decoded bundle.
  - Flush has priority over stall; both clear EX only. MEM and WB always advance.
  - Latency: decode to MemRead_MEM = 2 cycles; decode to RegWrite_WB = 3 cycles.
- FSM states RUN, DRAIN, HALTED.
  - RUN → DRAIN: opcode F in ID with !stall && !flush. A HALT under stall is retried next cycle; a HALT under flush is discarded.
  - DRAIN: down-counter loaded with DRAIN_CYCLES-1, decrements each cycle. → HALTED when the counter is 0.
  - HALTED → RUN: resume=1. resume is ignored in RUN and DRAIN.
- fetch_hold = 1 in DRAIN and HALTED, also combinationally on a HALT decode in RUN (fetch freezes that same cycle).
- halt = 1 only in HALTED (registered).
- Reset:
  - State RUN, counter 0, EX/MEM/WB = 0.
  - All registered outputs 0; halt=0, fetch_hold=0.
  - Reset mid-DRAIN or mid-HALTED returns to RUN immediately.
- Simultaneous events:
  - resume with reset: reset wins.
  - stall with flush: flush wins.
  - DRAIN_CYCLES=1: DRAIN lasts one cycle.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- When defined:
  - Adds outputs perf_retired, perf_stalls, perf_flushes (each CNT_W).
  - perf_retired increments when WB holds a non-bubble slot: a valid flag in the bundle is set when EX captures a real decode.
  - perf_stalls increments each cycle stall=1 && state==RUN.
  - perf_flushes increments each cycle flush=1.
  - Counters saturate at all-ones, clear on reset, hold while HALTED.
- When undefined: no ports, no counter logic; behaviour otherwise identical.

Test Plan:
- LOAD (0x8xxx) in ID, no stall → MemRead_EX=1 at cycle+1; MemRead_MEM=1, ResultSrc_MEM=1 at +2; RegWrite_WB=1 at +3.
- LOAD then ADD with stall=1 one cycle → EX bundle 0 during the stall cycle; MEM/WB keep advancing; ADD enters EX the next cycle.
- BEQ in ID with flush=1 → Branch=1, ImmSrc=10 that cycle; EX bundle 0 next cycle; RegWrite_MEM=0 two cycles later.
- HALT (0xF000), DRAIN_CYCLES=3 → fetch_hold=1 at once; halt=1 after 3 cycles in DRAIN; resume pulse → halt=0, fetch_hold=0 next cycle.
- reset asserted mid-DRAIN → state RUN, halt=0, all pipelined outputs 0 asynchronously.
- With PIPE_CTRL_PERF_EN: 5 ALU ops, 2 stall cycles, 1 flush → perf_retired=5, perf_stalls=2, perf_flushes=1 after drain.
